rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select of a shared 2:1 datapath mux and registers the muxed output.
- Requesters raise REQ0/REQ1 and present data on D0/D1.
- The arbiter grants one requester at a time, drives S (0 selects D0, 1 selects D1) and a registered Y/YV output stage.
- Ownership time is bounded by MAX_HOLD when the other side is waiting.

Parameters:
W, 8, data width of D0, D1 and Y
MAX_HOLD, 4, maximum consecutive granted cycles while the other requester waits; legal range 1 to 255

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
REQ0  input  1  requester 0 request; level, held until done
REQ1  input  1  requester 1 request; level, held until done
D0  input  W  requester 0 data
D1  input  W  requester 1 data
LOCK  input  1  holder requests extension past MAX_HOLD; functional only with GRANT_LOCK_EN, otherwise ignored
GNT0  output  1  registered grant to requester 0
GNT1  output  1  registered grant to requester 1
S  output  1  registered mux select; 0 selects D0, 1 selects D1
Y  output  W  registered muxed data
YV  output  1  Y holds valid granted data

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, applied at any time including mid-grant:
  - Next edge gives state IDLE.
  - GNT0=GNT1=0, S=0, Y=0, YV=0, hold counter=0.
  - LAST=1, so requester 0 wins the first tie.
- States:
  - IDLE: no grant.
  - G0: GNT0=1, S=0.
  - G1: GNT1=1, S=1.
  - GNT0 and GNT1 are never both 1.
- IDLE transitions:
  - REQ0 only: G0.
  - REQ1 only: G1.
  - Both: grant the side not equal to LAST.
  - Neither: stay in IDLE.
- Grant latency: 1 cycle from the first edge REQ is sampled high.
- Hold counter:
  - Cleared on entry to G0/G1.
  - Increments each granted cycle.
  - Saturates at MAX_HOLD.
- Gn transitions, evaluated each edge, n = holder, m = other:
  - REQn=0 and REQm=1: go to Gm. No idle bubble.
  - REQn=0 and REQm=0: go to IDLE.
  - REQn=1, REQm=1, counter = MAX_HOLD-1 (holder has had MAX_HOLD granted cycles): preempt, go to Gm.
  - REQn=1, REQm=0: stay in Gn regardless of counter value.
- Simultaneous holder drop and other-side request: switch directly, same as the REQn=0, REQm=1 case.
- LAST updates to n on every entry into Gn.
- Output stage, registered one cycle behind grant:
  - Y <= (S ? D1 : D0) and YV <= 1 while in G0/G1.
  - In IDLE: YV <= 0 and Y holds its last value.
  - Net effect: data presented by the holder in grant cycle k appears on Y in cycle k+1.
- MAX_HOLD=1 gives strict alternation under continuous contention.
- Width rules:
  - Counter width is clog2(MAX_HOLD+1).
  - Y is exactly W bits; no extension or truncation.

Optional Feature:
- Macro: GRANT_LOCK_EN.
- Defined:
  - While the holder keeps LOCK=1 with its REQ high, MAX_HOLD preemption is suppressed.
  - Releasing LOCK while the counter is at or past MAX_HOLD-1 with the other side requesting switches at the next edge.
  - LOCK has no effect in IDLE.
- Undefined: LOCK is ignored entirely; behaviour is exactly as above.

Test Plan:
- Reset: assert rst for 2 cycles during G1 with YV=1 -> next edge GNT0=GNT1=S=YV=0, Y=0; first tie afterwards grants requester 0.
- Single requester: REQ0=1 from cycle 0 to 9, D0=8'hA5 -> GNT0=1 cycles 1-10, S=0, Y=8'hA5 with YV=1 cycles 2-11, never preempted.
- Contention, MAX_HOLD=4: REQ0=REQ1=1 continuously from reset, D0=8'h11, D1=8'h22 -> grants in runs of 4 (G0 cycles 1-4, G1 cycles 5-8, ...); Y alternates 8'h11/8'h22 in runs of 4, one cycle later.
- Early release: in G0, drop REQ0 on the same edge REQ1 rises -> next cycle GNT1=1, S=1, no IDLE cycle; LAST=1.
- Both drop: holder releases with REQ1=0 -> IDLE next cycle; YV=0 one cycle after; Y retains the last value.
- GRANT_LOCK_EN defined: contention with LOCK=1 held by requester 0 for 10 cycles -> GNT0 stays 1 all 10 cycles; LOCK low -> switch to G1 at the next edge. Macro undefined, same stimulus -> switch after 4 cycles.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux; grant 1 cycle after request, Y 1 cycle after grant.
// Holder keeps ownership while alone; preempted after MAX_HOLD cycles under contention (LOCK extends it when GRANT_LOCK_EN is defined).
module rr_mux_arbiter #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic         LOCK,
    output logic         GNT0,
    output logic         GNT1,
    output logic         S,
    output logic [W-1:0] Y,
    output logic         YV
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   y_q, y_d;
    logic           yv_q, yv_d;
    logic           lock_hold;
    logic           hold_expired;

`ifdef GRANT_LOCK_EN
    assign lock_hold = LOCK;
`else
    // LOCK is read but can never hold off preemption in this build.
    assign lock_hold = LOCK & 1'b0;
`endif

    // Counter at or past MAX_HOLD-1 means the holder has used its full share.
    assign hold_expired = (cnt_q >= HOLD_LAST) && !lock_hold;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    state_d = last_q ? G0 : G1;
                end else if (REQ0) begin
                    state_d = G0;
                end else if (REQ1) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (!REQ0) begin
                    state_d = REQ1 ? G1 : IDLE;
                end else if (REQ1 && hold_expired) begin
                    state_d = G1;
                end
            end
            G1: begin
                if (!REQ1) begin
                    state_d = REQ0 ? G0 : IDLE;
                end else if (REQ0 && hold_expired) begin
                    state_d = G0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (state_d == G0 && state_q != G0) begin
            last_d = 1'b0;
            cnt_d  = '0;
        end else if (state_d == G1 && state_q != G1) begin
            last_d = 1'b1;
            cnt_d  = '0;
        end else if (state_d != IDLE) begin
            cnt_d = (cnt_q == HOLD_SAT) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Output stage samples the mux one cycle behind the grant.
    always_comb begin
        y_d  = y_q;
        yv_d = 1'b0;
        if (state_q != IDLE) begin
            y_d  = (state_q == G1) ? D1 : D0;
            yv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign GNT0 = (state_q == G0);
    assign GNT1 = (state_q == G1);
    assign S    = (state_q == G1);
    assign Y    = y_q;
    assign YV   = yv_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed-vector bench for rr_mux_arbiter (W=8, MAX_HOLD=4).
module tb_rr_mux_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] D0   = 8'h00;
    logic [7:0] D1   = 8'h00;
    logic       LOCK = 1'b0;
    logic       GNT0, GNT1, S, YV;
    logic [7:0] Y;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.W(8), .MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .REQ0 (REQ0),
        .REQ1 (REQ1),
        .D0   (D0),
        .D1   (D1),
        .LOCK (LOCK),
        .GNT0 (GNT0),
        .GNT1 (GNT1),
        .S    (S),
        .Y    (Y),
        .YV   (YV)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        LOCK = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int g;
        int gp;

        // Reset in the middle of a G1 grant with YV high
        do_reset();
        chk("rst_init_gnt0", 32'(GNT0), 32'd0);
        chk("rst_init_yv", 32'(YV), 32'd0);
        D1   = 8'h5C;
        REQ1 = 1'b1;
        tick();
        chk("pre_g1_gnt1", 32'(GNT1), 32'd1);
        tick();
        chk("pre_g1_yv", 32'(YV), 32'd1);
        chk("pre_g1_y", 32'(Y), 32'h5C);
        rst = 1'b1;
        tick();
        chk("rst_gnt0", 32'(GNT0), 32'd0);
        chk("rst_gnt1", 32'(GNT1), 32'd0);
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_yv", 32'(YV), 32'd0);
        chk("rst_y", 32'(Y), 32'd0);
        tick();
        rst  = 1'b0;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        tick();
        chk("tie_gnt0", 32'(GNT0), 32'd1);
        chk("tie_gnt1", 32'(GNT1), 32'd0);

        // Single requester held for 10 cycles
        do_reset();
        D0   = 8'hA5;
        REQ0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("single_gnt0", 32'(GNT0), (k <= 10) ? 32'd1 : 32'd0);
            chk("single_gnt1", 32'(GNT1), 32'd0);
            chk("single_s", 32'(S), 32'd0);
            if (k >= 2) begin
                chk("single_yv", 32'(YV), (k <= 11) ? 32'd1 : 32'd0);
                chk("single_y", 32'(Y), 32'hA5);
            end
            if (k == 10) REQ0 = 1'b0;
        end

        // Continuous contention: runs of 4
        do_reset();
        D0   = 8'h11;
        D1   = 8'h22;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            g = ((k - 1) / 4) % 2;
            chk("cont_gnt0", 32'(GNT0), (g == 0) ? 32'd1 : 32'd0);
            chk("cont_gnt1", 32'(GNT1), (g == 1) ? 32'd1 : 32'd0);
            chk("cont_s", 32'(S), 32'(g));
            if (k >= 2) begin
                gp = ((k - 2) / 4) % 2;
                chk("cont_yv", 32'(YV), 32'd1);
                chk("cont_y", 32'(Y), (gp == 0) ? 32'h11 : 32'h22);
            end
        end

        // Early release: holder drops as the other side rises
        do_reset();
        D0   = 8'h3C;
        D1   = 8'h7E;
        REQ0 = 1'b1;
        tick();
        chk("early_g0", 32'(GNT0), 32'd1);
        REQ0 = 1'b0;
        REQ1 = 1'b1;
        tick();
        chk("early_gnt1", 32'(GNT1), 32'd1);
        chk("early_gnt0", 32'(GNT0), 32'd0);
        chk("early_s", 32'(S), 32'd1);
        chk("early_y", 32'(Y), 32'h3C);

        // Both drop: IDLE, YV falls a cycle later, Y retained
        REQ1 = 1'b0;
        tick();
        chk("drop_gnt0", 32'(GNT0), 32'd0);
        chk("drop_gnt1", 32'(GNT1), 32'd0);
        chk("drop_yv_lag", 32'(YV), 32'd1);
        chk("drop_y_lag", 32'(Y), 32'h7E);
        D1 = 8'h00;
        tick();
        chk("drop_yv", 32'(YV), 32'd0);
        chk("drop_y_hold", 32'(Y), 32'h7E);
        // LAST is now 1, so a tie goes to requester 0
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        tick();
        chk("last_tie_gnt0", 32'(GNT0), 32'd1);
        chk("last_tie_gnt1", 32'(GNT1), 32'd0);

        // LOCK held by requester 0 under contention
        do_reset();
        D0   = 8'h11;
        D1   = 8'h22;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        LOCK = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
`ifdef GRANT_LOCK_EN
            g = (k <= 10) ? 0 : 1;
`else
            g = ((k - 1) / 4) % 2;
`endif
            chk("lock_gnt0", 32'(GNT0), (g == 0) ? 32'd1 : 32'd0);
            chk("lock_gnt1", 32'(GNT1), (g == 1) ? 32'd1 : 32'd0);
            if (k == 10) LOCK = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
